// File: rtl/rot_seq_ctrl.sv
// Rotate-engine sequencer: walks the source row-major, one read then one write per pixel.
// Zero-wait latency 3 cycles/pixel; valid/addr/data hold until ready, one pixel in flight.
module rot_seq_ctrl #(
    parameter int DIM_W     = 12,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BPP_SHIFT = 2
) (
    input  logic                 I_HCLK,
    input  logic                 I_HRESET_N,
    input  logic                 I_START,
    input  logic                 I_ABORT,
    input  logic [ADDR_W-1:0]    I_SRC_ADDR,
    input  logic [ADDR_W-1:0]    I_DST_ADDR,
    input  logic [DIM_W-1:0]     I_WIDTH,
    input  logic [DIM_W-1:0]     I_HEIGHT,
    input  logic [1:0]           I_MODE,
    output logic                 O_BUSY,
    output logic                 O_DONE,
    output logic                 O_ERR,
    output logic                 O_ABORTED,
    output logic [2*DIM_W-1:0]   O_PIX_CNT,
    output logic                 O_RD_VALID,
    output logic [ADDR_W-1:0]    O_RD_ADDR,
    input  logic                 I_RD_READY,
    input  logic                 I_RDATA_VALID,
    input  logic [DATA_W-1:0]    I_RDATA,
    output logic                 O_WR_VALID,
    output logic [ADDR_W-1:0]    O_WR_ADDR,
    output logic [DATA_W-1:0]    O_WR_DATA,
    input  logic                 I_WR_READY
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_DONE
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    src_q, dst_q;
    logic [DIM_W-1:0]     w_q, h_q, x_q, y_q;
    logic [1:0]           mode_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [2*DIM_W-1:0]   pix_q;
    logic                 err_q, aborted_q, abort_q;

    logic [DIM_W-1:0]     xd, yd, stride;
    logic [ADDR_W-1:0]    rd_off, wr_off;
    logic                 last_col, last_row;

    // Destination coordinates and row stride of the rotated image for the current pixel.
    always_comb begin
        xd     = x_q;
        yd     = y_q;
        stride = w_q;
        case (mode_q)
            2'd1: begin
                xd     = h_q - y_q - DIM_W'(1);
                yd     = x_q;
                stride = h_q;
            end
            2'd2: begin
                xd = w_q - x_q - DIM_W'(1);
                yd = h_q - y_q - DIM_W'(1);
            end
            2'd3: begin
                xd     = y_q;
                yd     = w_q - x_q - DIM_W'(1);
                stride = h_q;
            end
            default: ;
        endcase
    end

    assign rd_off   = ADDR_W'(y_q) * ADDR_W'(w_q) + ADDR_W'(x_q);
    assign wr_off   = ADDR_W'(yd) * ADDR_W'(stride) + ADDR_W'(xd);
    assign last_col = (x_q == w_q - DIM_W'(1));
    assign last_row = (y_q == h_q - DIM_W'(1));

    assign O_BUSY     = (state != S_IDLE);
    assign O_DONE     = (state == S_DONE);
    assign O_RD_VALID = (state == S_RD_REQ);
    assign O_WR_VALID = (state == S_WR_REQ);
    assign O_RD_ADDR  = O_RD_VALID ? src_q + (rd_off << BPP_SHIFT) : '0;
    assign O_WR_ADDR  = O_WR_VALID ? dst_q + (wr_off << BPP_SHIFT) : '0;
    assign O_WR_DATA  = wdata_q;
    assign O_ERR      = err_q;
    assign O_ABORTED  = aborted_q;
    assign O_PIX_CNT  = pix_q;

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state     <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            w_q       <= '0;
            h_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            mode_q    <= '0;
            wdata_q   <= '0;
            pix_q     <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            // Abort is only honoured at a write handshake, so it is remembered until then.
            if (state != S_IDLE && I_ABORT)
                abort_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (I_START) begin
                        src_q     <= I_SRC_ADDR;
                        dst_q     <= I_DST_ADDR;
                        w_q       <= I_WIDTH;
                        h_q       <= I_HEIGHT;
                        mode_q    <= I_MODE;
                        err_q     <= 1'b0;
                        aborted_q <= 1'b0;
                        abort_q   <= 1'b0;
                        pix_q     <= '0;
                        x_q       <= '0;
                        y_q       <= '0;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_q == '0 || h_q == '0) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (I_RD_READY)
                        state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (I_RDATA_VALID) begin
                        wdata_q <= I_RDATA;
                        state   <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (I_WR_READY) begin
                        pix_q <= pix_q + 1'b1;
                        if (last_col) begin
                            x_q <= '0;
                            y_q <= y_q + 1'b1;
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                        if (last_col && last_row) begin
                            state <= S_DONE;
                        end else if (abort_q) begin
                            aborted_q <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_RD_REQ;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Bench for rot_seq_ctrl: randomized slaves plus a rotation model built by repeated 90-degree turns.
module tb_rot_seq_ctrl;

    logic        I_HCLK;
    logic        I_HRESET_N;
    logic        I_START, I_ABORT;
    logic [31:0] I_SRC_ADDR, I_DST_ADDR;
    logic [11:0] I_WIDTH, I_HEIGHT;
    logic [1:0]  I_MODE;
    logic        O_BUSY, O_DONE, O_ERR, O_ABORTED;
    logic [23:0] O_PIX_CNT;
    logic        O_RD_VALID, I_RD_READY, I_RDATA_VALID;
    logic [31:0] O_RD_ADDR, I_RDATA;
    logic        O_WR_VALID, I_WR_READY;
    logic [31:0] O_WR_ADDR, O_WR_DATA;

    rot_seq_ctrl dut (
        .I_HCLK(I_HCLK), .I_HRESET_N(I_HRESET_N), .I_START(I_START), .I_ABORT(I_ABORT),
        .I_SRC_ADDR(I_SRC_ADDR), .I_DST_ADDR(I_DST_ADDR), .I_WIDTH(I_WIDTH),
        .I_HEIGHT(I_HEIGHT), .I_MODE(I_MODE), .O_BUSY(O_BUSY), .O_DONE(O_DONE),
        .O_ERR(O_ERR), .O_ABORTED(O_ABORTED), .O_PIX_CNT(O_PIX_CNT),
        .O_RD_VALID(O_RD_VALID), .O_RD_ADDR(O_RD_ADDR), .I_RD_READY(I_RD_READY),
        .I_RDATA_VALID(I_RDATA_VALID), .I_RDATA(I_RDATA), .O_WR_VALID(O_WR_VALID),
        .O_WR_ADDR(O_WR_ADDR), .O_WR_DATA(O_WR_DATA), .I_WR_READY(I_WR_READY)
    );

    initial begin
        I_HCLK = 1'b0;
        forever #5 I_HCLK = ~I_HCLK;
    end

    int          errors = 0;
    int          checks = 0;
    bit          noisy  = 1'b0;
    bit          chk_en = 1'b0;
    logic [31:0] salt   = 32'h0;
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wr[$];
    int          rd_idx = 0;
    int          wr_idx = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ salt;
    endfunction

    // Reference: source pixel order is row-major; each mode is that many clockwise quarter turns.
    task automatic build_model(input logic [31:0] src, input logic [31:0] dst,
                               input int w, input int h, input int mode);
        int xd, yd, wd, hd, t;
        exp_rd.delete();
        exp_wr.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                exp_rd.push_back(src + 32'((y * w + x) * 4));
                xd = x; yd = y; wd = w; hd = h;
                for (int r = 0; r < mode; r++) begin
                    t  = xd;
                    xd = hd - 1 - yd;
                    yd = t;
                    t  = wd;
                    wd = hd;
                    hd = t;
                end
                exp_wr.push_back(dst + 32'((yd * wd + xd) * 4));
            end
        end
    endtask

    // Slave models: random ready, 0-5 cycle read latency, stray data strobes when no read is pending.
    initial begin
        bit          pend;
        int          lat;
        logic [31:0] pdat;
        pend = 1'b0; lat = 0; pdat = '0;
        I_RD_READY = 1'b0; I_WR_READY = 1'b0; I_RDATA_VALID = 1'b0; I_RDATA = '0;
        forever begin
            @(negedge I_HCLK);
            if (O_RD_VALID && I_RD_READY && !pend) begin
                pend = 1'b1;
                pdat = mem(O_RD_ADDR);
                lat  = noisy ? int'($urandom_range(0, 5)) : 0;
            end
            @(posedge I_HCLK);
            #1;
            if (!I_HRESET_N) pend = 1'b0;
            if (pend && lat == 0) begin
                I_RDATA_VALID = 1'b1;
                I_RDATA       = pdat;
                pend          = 1'b0;
            end else begin
                if (pend) lat--;
                I_RDATA_VALID = noisy && !pend && ($urandom_range(0, 3) == 0);
                I_RDATA       = $urandom;
            end
            I_RD_READY = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
            I_WR_READY = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Per-cycle compare against the model: order, stability, exclusivity and pixel count.
    initial begin
        logic        prv_rv, prv_rr, prv_wv, prv_wr;
        logic [31:0] prv_ra, prv_wa, prv_wd;
        prv_rv = 0; prv_rr = 0; prv_wv = 0; prv_wr = 0;
        prv_ra = 0; prv_wa = 0; prv_wd = 0;
        forever begin
            @(negedge I_HCLK);
            if (chk_en) begin
                check(!(O_RD_VALID && O_WR_VALID), "both_valid", {O_RD_VALID, O_WR_VALID}, 0);
                if (prv_rv && !prv_rr)
                    check(O_RD_VALID && O_RD_ADDR == prv_ra, "rd_stable", O_RD_ADDR, prv_ra);
                if (prv_wv && !prv_wr)
                    check(O_WR_VALID && O_WR_ADDR == prv_wa && O_WR_DATA == prv_wd,
                          "wr_stable", {O_WR_ADDR, O_WR_DATA}, {prv_wa, prv_wd});
                check(int'(O_PIX_CNT) == wr_idx, "pix_cnt_run", O_PIX_CNT, wr_idx);
                if (O_RD_VALID && I_RD_READY) begin
                    if (rd_idx < exp_rd.size())
                        check(O_RD_ADDR == exp_rd[rd_idx], "rd_addr", O_RD_ADDR, exp_rd[rd_idx]);
                    else
                        check(1'b0, "rd_extra", O_RD_ADDR, rd_idx);
                    rd_idx++;
                end
                if (O_WR_VALID && I_WR_READY) begin
                    if (wr_idx < exp_wr.size()) begin
                        check(O_WR_ADDR == exp_wr[wr_idx], "wr_addr", O_WR_ADDR, exp_wr[wr_idx]);
                        check(O_WR_DATA == mem(exp_rd[wr_idx]), "wr_data", O_WR_DATA, mem(exp_rd[wr_idx]));
                    end else begin
                        check(1'b0, "wr_extra", O_WR_ADDR, wr_idx);
                    end
                    wr_idx++;
                end
                prv_rv = O_RD_VALID; prv_rr = I_RD_READY; prv_ra = O_RD_ADDR;
                prv_wv = O_WR_VALID; prv_wr = I_WR_READY; prv_wa = O_WR_ADDR; prv_wd = O_WR_DATA;
            end else begin
                prv_rv = 0; prv_wv = 0;
            end
        end
    end

    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int w, input int h,
                           input int mode, input int n_exp, input int exp_cyc, input bit exp_err,
                           input bit exp_ab, input int abort_k, input int restart_k);
        int k;
        bit got;
        salt = $urandom;
        build_model(src, dst, w, h, mode);
        rd_idx = 0;
        wr_idx = 0;
        @(posedge I_HCLK);
        #1;
        I_SRC_ADDR = src; I_DST_ADDR = dst; I_WIDTH = 12'(w); I_HEIGHT = 12'(h);
        I_MODE = 2'(mode); I_START = 1'b1;
        @(posedge I_HCLK);
        #1;
        I_START = 1'b0;
        chk_en  = 1'b1;
        got     = 1'b0;
        k       = 1;
        while (k < 3000) begin
            I_ABORT = (k == abort_k);
            I_START = (k == restart_k);
            if (k == restart_k) begin
                I_SRC_ADDR = 32'hDEAD_0000; I_WIDTH = 12'd1; I_MODE = 2'(mode + 1);
            end
            @(negedge I_HCLK);
            check(O_BUSY == 1'b1, "busy", O_BUSY, 1);
            if (k == 1) check({O_ERR, O_ABORTED} == 2'b00, "sticky_clear", {O_ERR, O_ABORTED}, 0);
            if (O_DONE) begin
                got = 1'b1;
                break;
            end
            @(posedge I_HCLK);
            #1;
            k++;
        end
        I_ABORT = 1'b0;
        I_START = 1'b0;
        if (!got) begin
            check(1'b0, "done_timeout", k, 3000);
            chk_en = 1'b0;
            return;
        end
        if (exp_cyc >= 0) check(k == exp_cyc, "done_cycle", k, exp_cyc);
        check(int'(O_PIX_CNT) == n_exp, "pix_cnt_done", O_PIX_CNT, n_exp);
        check(O_ERR == exp_err, "err", O_ERR, exp_err);
        check(O_ABORTED == exp_ab, "aborted", O_ABORTED, exp_ab);
        check(rd_idx == n_exp && wr_idx == n_exp, "xfer_count", {rd_idx, wr_idx}, n_exp);
        @(posedge I_HCLK);
        #1;
        @(negedge I_HCLK);
        check(!O_DONE && !O_BUSY, "idle_after_done", {O_DONE, O_BUSY}, 0);
        check(int'(O_PIX_CNT) == n_exp && O_ERR == exp_err && O_ABORTED == exp_ab,
              "status_hold", {O_PIX_CNT, O_ERR, O_ABORTED}, {n_exp[23:0], exp_err, exp_ab});
        chk_en = 1'b0;
    endtask

    function automatic logic outs_nonzero();
        return |{O_BUSY, O_DONE, O_ERR, O_ABORTED, O_PIX_CNT, O_RD_VALID, O_RD_ADDR,
                 O_WR_VALID, O_WR_ADDR, O_WR_DATA};
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pin_m1[6];
        logic [31:0] pin_m3[6];
        logic [31:0] pin_m2[4];
        int          w, h;
        pin_m1 = '{32'h2004, 32'h200C, 32'h2014, 32'h2000, 32'h2008, 32'h2010};
        pin_m3 = '{32'h2010, 32'h2008, 32'h2000, 32'h2014, 32'h200C, 32'h2004};
        pin_m2 = '{32'h200C, 32'h2008, 32'h2004, 32'h2000};

        I_HRESET_N = 1'b0; I_START = 1'b0; I_ABORT = 1'b0;
        I_SRC_ADDR = '0; I_DST_ADDR = '0; I_WIDTH = '0; I_HEIGHT = '0; I_MODE = '0;
        repeat (3) @(posedge I_HCLK);
        #1;
        check(!outs_nonzero(), "reset_outputs", outs_nonzero(), 0);
        I_HRESET_N = 1'b1;

        // Model pins against hand-derived address lists.
        build_model(32'h1000, 32'h2000, 3, 2, 1);
        for (int i = 0; i < 6; i++) check(exp_wr[i] == pin_m1[i], "pin_mode1", exp_wr[i], pin_m1[i]);
        check(exp_rd[5] == 32'h1014, "pin_rd_last", exp_rd[5], 32'h1014);
        build_model(32'h1000, 32'h2000, 3, 2, 3);
        for (int i = 0; i < 6; i++) check(exp_wr[i] == pin_m3[i], "pin_mode3", exp_wr[i], pin_m3[i]);
        build_model(32'h1000, 32'h2000, 2, 2, 2);
        for (int i = 0; i < 4; i++) check(exp_wr[i] == pin_m2[i], "pin_mode2", exp_wr[i], pin_m2[i]);

        // Zero-wait jobs: exact completion time 3*W*H+2.
        noisy = 1'b0;
        run_job(32'h1000, 32'h2000, 3, 2, 1, 6, 20, 0, 0, -1, -1);
        @(posedge I_HCLK); #1; I_ABORT = 1'b1;
        @(posedge I_HCLK); #1; I_ABORT = 1'b0;
        run_job(32'h1000, 32'h2000, 3, 2, 3, 6, 20, 0, 0, -1, -1);
        run_job(32'h1000, 32'h2000, 2, 2, 2, 4, 14, 0, 0, -1, -1);
        run_job(32'h1000, 32'h2000, 3, 2, 0, 6, 20, 0, 0, -1, -1);
        run_job(32'hFFFF_FFF8, 32'hFFFF_FFF0, 2, 3, 1, 6, 20, 0, 0, -1, -1);

        // Zero dimension rejected, next accepted job clears ERR.
        run_job(32'h1000, 32'h2000, 0, 5, 0, 0, 2, 1, 0, -1, -1);
        run_job(32'h1000, 32'h2000, 3, 2, 0, 6, 20, 0, 0, -1, -1);

        // Abort in the 2nd pixel's read wait with an ignored START mid-job.
        run_job(32'h1000, 32'h2000, 3, 2, 1, 2, 8, 0, 1, 6, 3);
        // Abort coinciding with the final write completes normally.
        run_job(32'h3000, 32'h4000, 1, 1, 2, 1, 5, 0, 0, 4, -1);

        // Backpressure and read latency.
        noisy = 1'b1;
        run_job(32'h1000, 32'h2000, 4, 3, 1, 12, -1, 0, 0, -1, -1);
        for (int j = 0; j < 6; j++) begin
            w = int'($urandom_range(1, 5));
            h = int'($urandom_range(1, 5));
            run_job({$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC, w, h,
                    int'($urandom_range(0, 3)), w * h, -1, 0, 0, -1, -1);
        end
        noisy = 1'b0;
        repeat (8) @(posedge I_HCLK);

        // Asynchronous reset in the middle of a write request.
        salt = $urandom;
        build_model(32'h1000, 32'h2000, 3, 2, 1);
        rd_idx = 0; wr_idx = 0;
        @(posedge I_HCLK); #1;
        I_SRC_ADDR = 32'h1000; I_DST_ADDR = 32'h2000; I_WIDTH = 12'd3; I_HEIGHT = 12'd2;
        I_MODE = 2'd1; I_START = 1'b1;
        @(posedge I_HCLK); #1;
        I_START = 1'b0;
        chk_en  = 1'b1;
        repeat (3) @(posedge I_HCLK);
        @(negedge I_HCLK);
        check(O_WR_VALID == 1'b1, "pre_reset_wr", O_WR_VALID, 1);
        chk_en = 1'b0;
        #1;
        I_HRESET_N = 1'b0;
        #1;
        check(!outs_nonzero(), "async_reset_outputs", outs_nonzero(), 0);
        repeat (2) @(posedge I_HCLK);
        #1;
        I_HRESET_N = 1'b1;
        @(negedge I_HCLK);
        check(!outs_nonzero(), "post_reset_idle", outs_nonzero(), 0);
        run_job(32'h1000, 32'h2000, 3, 2, 1, 6, 20, 0, 0, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
